free_list: RTL and testbench

Returns every node of a card linked list to the free pool by walking it from its head address and clearing each node's allocation bit in the shared 1024x32 card RAM. It is the release-side counterpart of the block allocator. It sits beside the add, remove and split operations under the RAM controller and drives the same RAM port bundle, selected by the controller's operation mux.

---
 rtl/card_mem_pkg.sv | 46 ++++
 rtl/free_list.sv | 178 +++++++++++++++++
 tb/tb_free_list.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_mem_pkg.sv
// ---------------------------------------------------------------------------
// card_mem_pkg
//
// Shared definitions for the blocks that operate on the 1024x32 card RAM
// (allocator, add, remove, split, free_list).
//
//   - Field positions inside a node word.
//   - NULL_ADDR, the list terminator. Address 0 is never a real node.
//   - card_word_t and card_node_t, the raw and the field-level views of a word.
//   - Error codes reported by free_list.
// ---------------------------------------------------------------------------
package card_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 32;

  // Bit positions inside a node word.
  localparam int ALLOC_BIT = 31;
  localparam int SUIT_HI   = 15;
  localparam int SUIT_LO   = 14;
  localparam int VALUE_HI  = 13;
  localparam int VALUE_LO  = 10;
  localparam int NEXT_HI   = 9;
  localparam int NEXT_LO   = 0;

  typedef logic [ADDR_W-1:0] card_addr_t;
  typedef logic [WORD_W-1:0] card_word_t;

  // Field view of a node word. Bits 30:16 carry no meaning for list walks.
  typedef struct packed {
    logic        alloc;
    logic [14:0] rsvd;
    logic [1:0]  suit;
    logic [3:0]  value;
    card_addr_t  next;
  } card_node_t;

  localparam card_addr_t NULL_ADDR = '0;

  // Completion status of a free_list walk.
  typedef logic [1:0] free_err_t;
  localparam free_err_t ERR_OK          = 2'd0;
  localparam free_err_t ERR_DOUBLE_FREE = 2'd1;
  localparam free_err_t ERR_LIMIT       = 2'd2;

endpackage : card_mem_pkg

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//
// Walks a card linked list from its head and clears the allocation flag
// of every node, which hands the nodes back to the block allocator. Each
// node takes four cycles: READ, WAIT, CHECK and CLEAR. The RAM returns
// read data two cycles after the address is presented.
//
// Build option:
//   FREE_LIST_SCRUB_EN  defined   : a freed node is written as 32'h0.
//                       undefined : a freed node keeps bits 30:0 for debug.
//
// Parameters:
//   MAX_NODES     A walk that would go past this many nodes is treated as
//                 a cycle and stops with error 2.
//
// Ports:
//   clock         block and RAM clock
//   resetn        asynchronous active-low reset
//   start         one-cycle walk request. It is sampled only when idle.
//   head          first node address. 0 means an empty list.
//   busy          high while nodes are being walked
//   done          one-cycle pulse when the walk ends
//   error         0 ok, 1 double free, 2 node limit. Held with freed_count.
//   freed_count   nodes freed by the last walk. Held until the next start.
//   ram_address   RAM address
//   ram_clock     RAM clock (same as clock)
//   ram_data      RAM write data
//   ram_wren      RAM write enable
//   ram_q         RAM read data
// ---------------------------------------------------------------------------
import card_mem_pkg::*;

module free_list #(
  parameter int MAX_NODES = 1023
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [9:0]  head,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic [9:0]  freed_count,
  output logic [9:0]  ram_address,
  output logic        ram_clock,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_CLEAR,
    S_FIN
  } state_t;

  localparam card_addr_t MAX_COUNT = card_addr_t'(MAX_NODES);

  state_t     state, state_d;
  card_addr_t cur;        // node being freed
  card_addr_t next_addr;  // successor, captured in CHECK
  card_word_t node_word;  // node contents, captured in CHECK
  card_addr_t count;
  free_err_t  err;
  logic       done_r;

  card_node_t node_q;
  card_addr_t count_inc;
  logic       at_limit;

  assign node_q    = card_node_t'(ram_q);
  assign count_inc = count + card_addr_t'(1);
  // The node cleared in this CLEAR is the last one the walk may free.
  assign at_limit  = (count_inc == MAX_COUNT);

  assign ram_clock   = clock;
  assign busy        = (state != S_IDLE) && (state != S_FIN);
  assign done        = done_r;
  assign error       = err;
  assign freed_count = count;

  // Word written back in CLEAR. The flag is cleared in both builds.
  card_word_t clear_word;
`ifdef FREE_LIST_SCRUB_EN
  assign clear_word = '0;
`else
  assign clear_word = {1'b0, node_word[ALLOC_BIT-1:0]};
`endif

  // Next-state and RAM port decode.
  always_comb begin
    // NOTE: every output gets a default first. Then any path that does not
    // assign a signal still has a value, and no latch is inferred.
    state_d     = state;
    ram_address = NULL_ADDR;
    ram_data    = '0;
    ram_wren    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_d = (head == NULL_ADDR) ? S_FIN : S_READ;
      end
      S_READ: begin
        ram_address = cur;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        ram_address = cur;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        ram_address = cur;
        state_d     = node_q.alloc ? S_CLEAR : S_FIN;
      end
      S_CLEAR: begin
        ram_address = cur;
        ram_data    = clear_word;
        ram_wren    = 1'b1;
        if (next_addr == NULL_ADDR || at_limit) state_d = S_FIN;
        else                                    state_d = S_READ;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and walk datapath.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cur       <= NULL_ADDR;
      next_addr <= NULL_ADDR;
      node_word <= '0;
      count     <= '0;
      err       <= ERR_OK;
      done_r    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments. Every register then
      // samples values from before this clock edge, whatever the statement order.
      state  <= state_d;
      done_r <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur   <= head;
            count <= '0;
            err   <= ERR_OK;
          end
        end
        S_CHECK: begin
          if (!node_q.alloc) begin
            err <= ERR_DOUBLE_FREE;
          end else begin
            next_addr <= node_q.next;
            node_word <= ram_q;
          end
        end
        S_CLEAR: begin
          count <= count_inc;
          cur   <= next_addr;
          if (next_addr != NULL_ADDR && at_limit) err <= ERR_LIMIT;
        end
        S_FIN: begin
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : free_list

// File: tb/tb_free_list.sv
`timescale 1ns/1ps
// Bench for free_list. It has a two-cycle-latency RAM model, table-driven
// list walks, and hand-written corner sequences. Randomized lists are
// checked against a list-walking reference model. The DUT uses a small
// node limit, so the abort path can be reached with short lists.
module tb_free_list;
  import card_mem_pkg::*;

  localparam int MAX_N  = 4;
  localparam int BUDGET = 200;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  head = '0;
  logic        busy, done, ram_clock, ram_wren;
  logic [1:0]  error;
  logic [9:0]  freed_count, ram_address;
  logic [31:0] ram_data, ram_q;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  free_list #(.MAX_NODES(MAX_N)) dut (
    .clock(clock), .resetn(resetn), .start(start), .head(head),
    .busy(busy), .done(done), .error(error), .freed_count(freed_count),
    .ram_address(ram_address), .ram_clock(ram_clock), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // RAM with a registered address and registered output.
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [9:0]  addr_r = '0;
  logic [31:0] q_r = '0;
  always @(posedge ram_clock) begin
    addr_r <= ram_address;
    q_r    <= mem[addr_r];
    if (ram_wren) mem[ram_address] <= ram_data;
  end
  assign ram_q = q_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record writes and done pulses mid-cycle.
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_pulses = 0;
  logic        prev_wren = 1'b0;
  always @(negedge clock) begin
    if (ram_wren) begin
      check("wren_not_back_to_back", 32'(prev_wren), 32'd0);
      wr_addr.push_back(ram_address);
      wr_data.push_back(ram_data);
    end
    prev_wren = ram_wren;
    if (done) done_pulses++;
  end

  function automatic logic [31:0] freed_word(input logic [31:0] w);
`ifdef FREE_LIST_SCRUB_EN
    return 32'h0;
`else
    return {1'b0, w[30:0]};
`endif
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  // Start a walk and wait for done. The latency counts the accepting edge as 1.
  // If pulse_at > 0, start is pulsed again with another head on that cycle.
  task automatic do_walk(input logic [9:0] h, input int pulse_at, output int lat);
    wr_addr.delete();
    wr_data.delete();
    done_pulses = 0;
    @(posedge clock); #1;
    start = 1'b1; head = h;
    @(posedge clock); #1;
    start = 1'b0; head = '0;
    lat = 1;
    check("busy_after_start", 32'(busy), 32'(h != 10'd0));
    while (!done && lat < BUDGET) begin
      start = (lat == pulse_at);
      head  = (lat == pulse_at) ? 10'h077 : 10'h000;
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0; head = '0;
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  // Results at done, and that they hold afterwards with a single done pulse.
  task automatic post_walk(input string tag, input int lat, input logic [1:0] e,
                           input int n, input int exp_lat);
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_count"}, 32'(freed_count), 32'(n));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
    check({tag, "_error_held"}, 32'(error), 32'(e));
    check({tag, "_count_held"}, 32'(freed_count), 32'(n));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_write_count"}, 32'(wr_addr.size()), 32'(n));
  endtask

  function automatic logic [9:0] list_addr(input int i);
    return 10'(37 * i + 11);
  endfunction

  // Build a list of len nodes. Node number `bad_pos` (1-based) is already free.
  task automatic build_list(input int len, input int bad_pos, output logic [9:0] h);
    logic [9:0] nx;
    for (int i = 0; i < len; i++) begin
      nx = (i + 1 < len) ? list_addr(i + 1) : NULL_ADDR;
      mem[list_addr(i)] = {(i + 1 != bad_pos), 15'h0, 2'(i), 4'(i + 3), nx};
    end
    h = (len > 0) ? list_addr(0) : NULL_ADDR;
  endtask

  // Reference model, written directly from the list rules. It works on
  // ref_mem and fills exp_seq with the freed addresses in order.
  logic [9:0] exp_seq[$];
  task automatic model_walk(input logic [9:0] h, output logic [1:0] e, output int n);
    logic [9:0]  cur;
    logic [31:0] w;
    cur = h; e = ERR_OK; n = 0;
    exp_seq.delete();
    while (cur != NULL_ADDR) begin
      w = ref_mem[cur];
      if (!w[ALLOC_BIT]) begin e = ERR_DOUBLE_FREE; break; end
      ref_mem[cur] = freed_word(w);
      exp_seq.push_back(cur);
      n++;
      if (w[NEXT_HI:NEXT_LO] != NULL_ADDR && n == MAX_N) begin e = ERR_LIMIT; break; end
      cur = w[NEXT_HI:NEXT_LO];
    end
  endtask

  typedef struct {
    int         len;
    int         bad_pos;
    logic [1:0] err;
    int         cnt;
    int         lat;
  } vec_t;

  vec_t        vecs[$];
  int          lat, n, m_n;
  logic [9:0]  h;
  logic [1:0]  m_e;
  logic [9:0]  la[8];
  logic [31:0] w;
  int          len;
  logic        dup;

  initial begin
    // Reset state.
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_count", 32'(freed_count), 0);
    check("rst_ram_address", 32'(ram_address), 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_ram_wren", 32'(ram_wren), 0);
    clear_mem();
    #11 resetn = 1'b1;

    // Table: list length, pre-freed node, then the expected results (limit 4).
    vecs.push_back('{len:0, bad_pos:0, err:ERR_OK,          cnt:0, lat:2});
    vecs.push_back('{len:1, bad_pos:0, err:ERR_OK,          cnt:1, lat:6});
    vecs.push_back('{len:3, bad_pos:0, err:ERR_OK,          cnt:3, lat:14});
    vecs.push_back('{len:4, bad_pos:0, err:ERR_OK,          cnt:4, lat:18});
    vecs.push_back('{len:5, bad_pos:0, err:ERR_LIMIT,       cnt:4, lat:18});
    vecs.push_back('{len:6, bad_pos:0, err:ERR_LIMIT,       cnt:4, lat:18});
    vecs.push_back('{len:2, bad_pos:2, err:ERR_DOUBLE_FREE, cnt:1, lat:9});
    vecs.push_back('{len:3, bad_pos:1, err:ERR_DOUBLE_FREE, cnt:0, lat:5});
    vecs.push_back('{len:4, bad_pos:3, err:ERR_DOUBLE_FREE, cnt:2, lat:13});
    foreach (vecs[k]) begin
      clear_mem();
      build_list(vecs[k].len, vecs[k].bad_pos, h);
      do_walk(h, 0, lat);
      post_walk($sformatf("vec%0d", k), lat, vecs[k].err, vecs[k].cnt, vecs[k].lat);
      for (int i = 0; i < vecs[k].cnt; i++) begin
        check($sformatf("vec%0d_wr_addr%0d", k, i),
              32'((wr_addr.size() > i) ? wr_addr[i] : 10'h3ff), 32'(list_addr(i)));
        check($sformatf("vec%0d_flag%0d", k, i), 32'(mem[list_addr(i)][ALLOC_BIT]), 0);
      end
    end

    // The list 5 -> 9 -> 0x40.
    clear_mem();
    mem[5] = 32'h8000_4009; mem[9] = 32'h8000_8840; mem[10'h40] = 32'h8000_1000;
    do_walk(10'd5, 0, lat);
    post_walk("three", lat, ERR_OK, 3, 14);
    check("three_wr0", 32'((wr_addr.size() > 0) ? wr_addr[0] : 10'h3ff), 5);
    check("three_wr1", 32'((wr_addr.size() > 1) ? wr_addr[1] : 10'h3ff), 9);
    check("three_wr2", 32'((wr_addr.size() > 2) ? wr_addr[2] : 10'h3ff), 32'h40);
    check("three_flag5", 32'(mem[5][31]), 0);
    check("three_flag9", 32'(mem[9][31]), 0);
    check("three_flag40", 32'(mem[10'h40][31]), 0);

    // 5 -> 9, where 9 is already free.
    clear_mem();
    mem[5] = 32'h8000_0009; mem[9] = 32'h0000_0000;
    do_walk(10'd5, 0, lat);
    post_walk("dfree", lat, ERR_DOUBLE_FREE, 1, 9);
    check("dfree_wr0", 32'((wr_addr.size() > 0) ? wr_addr[0] : 10'h3ff), 5);

    // The cycle 5 -> 9 -> 5. Node 5 is already free when it is revisited,
    // so the double-free check fires before the limit of 4 is reached.
    clear_mem();
    mem[5] = 32'h8000_0009; mem[9] = 32'h8000_0005;
    do_walk(10'd5, 0, lat);
    post_walk("cycle", lat, ERR_DOUBLE_FREE, 2, 13);

    // Write-back contents. Node 0x30 points at 0x125, which ends the list.
    clear_mem();
    mem[10'h30] = 32'h8000_C925; mem[10'h125] = 32'h8000_0000;
    do_walk(10'h30, 0, lat);
    post_walk("scrub", lat, ERR_OK, 2, 10);
`ifdef FREE_LIST_SCRUB_EN
    check("scrub_word", mem[10'h30], 32'h0000_0000);
`else
    check("scrub_word", mem[10'h30], 32'h0000_C925);
`endif

    // A second start during the walk is ignored.
    clear_mem();
    build_list(3, 0, h);
    mem[10'h077] = 32'h8000_0000;
    do_walk(h, 5, lat);
    post_walk("restart", lat, ERR_OK, 3, 14);
    check("restart_untouched", 32'(mem[10'h077][31]), 1);

    // Reset during WAIT of the second node.
    clear_mem();
    mem[5] = 32'h8000_0009; mem[9] = 32'h8000_0040; mem[10'h40] = 32'h8000_0000;
    done_pulses = 0;
    @(posedge clock); #1;
    start = 1'b1; head = 10'd5;
    @(posedge clock); #1;
    start = 1'b0; head = '0;
    repeat (5) @(posedge clock);
    #1;
    check("rst_mid_count_before", 32'(freed_count), 1);
    check("rst_mid_busy_before", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_error", 32'(error), 0);
    check("rst_mid_count", 32'(freed_count), 0);
    check("rst_mid_addr", 32'(ram_address), 0);
    check("rst_mid_data", ram_data, 0);
    check("rst_mid_wren", 32'(ram_wren), 0);
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("rst_mid_no_done", 32'(done_pulses), 0);
    check("rst_mid_flag5", 32'(mem[5][31]), 0);
    check("rst_mid_flag9", 32'(mem[9][31]), 1);
    check("rst_mid_flag40", 32'(mem[10'h40][31]), 1);

    // Random lists against the reference model.
    for (int it = 0; it < 40; it++) begin
      clear_mem();
      len = int'($urandom_range(0, 6));
      for (int i = 0; i < len; i++) begin
        do begin
          la[i] = 10'($urandom_range(1, 1023));
          dup = 1'b0;
          for (int j = 0; j < i; j++) if (la[j] == la[i]) dup = 1'b1;
        end while (dup);
      end
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        w[ALLOC_BIT] = ($urandom_range(0, 7) != 0);
        w[NEXT_HI:NEXT_LO] = (i + 1 < len) ? la[i + 1] : NULL_ADDR;
        if (i + 1 == len && $urandom_range(0, 3) == 0)
          w[NEXT_HI:NEXT_LO] = la[$urandom_range(0, len - 1)];
        mem[la[i]] = w;
      end
      h = (len > 0) ? la[0] : NULL_ADDR;
      for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
      model_walk(h, m_e, m_n);
      do_walk(h, 0, lat);
      n = (m_e == ERR_DOUBLE_FREE) ? 4 * m_n + 5 : 4 * m_n + 2;
      post_walk($sformatf("rnd%0d", it), lat, m_e, m_n, n);
      foreach (exp_seq[i])
        check($sformatf("rnd%0d_wr%0d", it, i),
              32'((wr_addr.size() > i) ? wr_addr[i] : 10'h3ff), 32'(exp_seq[i]));
      for (int i = 0; i < len; i++)
        check($sformatf("rnd%0d_mem%0d", it, i), mem[la[i]], ref_mem[la[i]]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_free_list
